// File: rtl/axil_pkg.sv
// Shared AXI-lite definitions used by the AXI-lite blocks of this codebase:
// response codes and byte-address helpers.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Number of byte-offset address bits below the word index for a data_width-bit bus.
    function automatic int unsigned addr_lsb(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

    function automatic logic resp_is_ok(input logic [1:0] resp);
        return (resp == RESP_OKAY) || (resp == RESP_EXOKAY);
    endfunction

    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
    endfunction

endpackage

// File: rtl/axil_read_responder_if.sv
// AXI-lite read channels (AR and R) between a read master and a read responder.
interface axil_read_responder_if #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [2:0]            arprot;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;

    modport master (
        output araddr, arprot, arvalid, rready,
        input  arready, rdata, rresp, rvalid
    );

    modport slave (
        input  araddr, arprot, arvalid, rready,
        output arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_rd_skid.sv
// Two-entry read-beat output stage: a head slot whose payload comes from a synchronous
// source one cycle after the in handshake, plus one skid entry holding the older beat.
module axil_rd_skid #(
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);
    logic             head_vld_r;
    logic             skid_vld_r;
    logic             in_ready_r;
    logic [WIDTH-1:0] skid_data_r;
    logic             in_fire_s;
    logic             out_fire_s;
    logic             skid_load_s;
    logic             head_vld_s;
    logic             skid_vld_s;

    assign in_fire_s  = in_valid && in_ready_r;
    assign out_valid  = skid_vld_r || head_vld_r;
    assign out_fire_s = out_valid && out_ready;
    assign out_data   = skid_vld_r ? skid_data_r : in_data;
    assign in_ready   = in_ready_r;

    // Next occupancy; a head beat that is neither leaving nor alone moves into the skid entry.
    always_comb begin
        skid_load_s = in_fire_s && head_vld_r && !skid_vld_r && !out_fire_s;
        head_vld_s  = head_vld_r;
        skid_vld_s  = skid_vld_r;
        if (in_fire_s) begin
            head_vld_s = 1'b1;
        end else if (out_fire_s && !skid_vld_r) begin
            head_vld_s = 1'b0;
        end else begin
            head_vld_s = head_vld_r;
        end
        if (skid_load_s) begin
            skid_vld_s = 1'b1;
        end else if (out_fire_s && skid_vld_r) begin
            skid_vld_s = 1'b0;
        end else begin
            skid_vld_s = skid_vld_r;
        end
    end

    // State registers; in_ready looks only at the post-edge occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_vld_r  <= 1'b0;
            skid_vld_r  <= 1'b0;
            in_ready_r  <= 1'b0;
            skid_data_r <= {WIDTH{1'b0}};
        end else begin
            head_vld_r <= head_vld_s;
            skid_vld_r <= skid_vld_s;
            in_ready_r <= !(head_vld_s && skid_vld_s);
            if (skid_load_s) begin
                skid_data_r <= in_data;
            end
        end
    end

endmodule

// File: rtl/axil_read_responder.sv
// AXI-lite read-only responder over a locally loaded synchronous RAM.
// Build option AXIL_READ_RESPONDER_RANGE_ERR_EN: word indices >= DEPTH return SLVERR with zero data.
module axil_read_responder
    import axil_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    axil_read_responder_if.slave     s_axil,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0]    wr_data,
    output logic [31:0]              rd_count
);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned LSB   = addr_lsb(DATA_WIDTH);
    localparam int unsigned PW    = DATA_WIDTH + 2;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_r;
    logic [1:0]            rd_resp_r;
    logic [31:0]           rd_count_r;
    logic [ADDR_WIDTH-1:0] araddr_s;
    logic [IDX_W-1:0]      rd_idx_s;
    logic                  rd_oob_s;
    logic                  ar_ready_s;
    logic                  ar_fire_s;
    logic                  r_fire_s;
    logic                  out_valid_s;
    logic [PW-1:0]         out_payload_s;
    logic                  unused_s;

    assign araddr_s  = s_axil.araddr;
    assign rd_idx_s  = araddr_s[LSB +: IDX_W];
    assign ar_fire_s = s_axil.arvalid && ar_ready_s;
`ifdef AXIL_READ_RESPONDER_RANGE_ERR_EN
    assign rd_oob_s  = |araddr_s[ADDR_WIDTH-1:LSB+IDX_W];
`else
    assign rd_oob_s  = 1'b0;
`endif
    assign unused_s  = ^{s_axil.arprot, araddr_s};

    // Load port; no reset so contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Synchronous read on AR accept; a same-cycle write to the word is seen only by later reads.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_r <= {DATA_WIDTH{1'b0}};
            rd_resp_r <= RESP_OKAY;
        end else if (ar_fire_s) begin
            if (rd_oob_s) begin
                rd_data_r <= {DATA_WIDTH{1'b0}};
                rd_resp_r <= RESP_SLVERR;
            end else begin
                rd_data_r <= mem[rd_idx_s];
                rd_resp_r <= RESP_OKAY;
            end
        end
    end

    axil_rd_skid #(
        .WIDTH(PW)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_valid (s_axil.arvalid),
        .in_ready (ar_ready_s),
        .in_data  ({rd_resp_r, rd_data_r}),
        .out_valid(out_valid_s),
        .out_ready(s_axil.rready),
        .out_data (out_payload_s)
    );

    assign r_fire_s = out_valid_s && s_axil.rready;

    // Completed R beat counter, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_r <= 32'd0;
        end else if (r_fire_s) begin
            rd_count_r <= rd_count_r + 32'd1;
        end
    end

    assign s_axil.arready = ar_ready_s;
    assign s_axil.rvalid  = out_valid_s;
    assign s_axil.rresp   = out_payload_s[PW-1:DATA_WIDTH];
    assign s_axil.rdata   = out_payload_s[DATA_WIDTH-1:0];
    assign rd_count       = rd_count_r;

endmodule

// File: tb/tb_axil_read_responder.sv
// Directed + random bench for axil_read_responder against a queue-based reference model.
module tb_axil_read_responder;
    localparam int unsigned DW    = 16;
    localparam int unsigned AW    = 32;
    localparam int unsigned DEPTH = 1024;
    localparam int unsigned IW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [IW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic [31:0]   rd_count;

    always #5 clk = ~clk;

    axil_read_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    axil_read_responder #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_axil  (bus),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_count(rd_count)
    );

    int            checks = 0;
    int            errors = 0;
    int            obs_accepts = 0;
    logic [DW-1:0] shadow [DEPTH];
    logic [DW+1:0] exp_q [$];
    logic [31:0]   exp_count = 32'd0;
    bit            in_rst_m = 1'b1;
    bit            started = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {rresp, rdata} for a byte address from the current memory image.
    function automatic logic [DW+1:0] beat(input logic [AW-1:0] addr);
        longint unsigned idx;
        idx = addr;
        idx = idx / (DW / 8);
`ifdef AXIL_READ_RESPONDER_RANGE_ERR_EN
        if (idx >= DEPTH) return {2'b10, {DW{1'b0}}};
        return {2'b00, shadow[idx]};
`else
        return {2'b00, shadow[idx % DEPTH]};
`endif
    endfunction

    // Check outputs against the model, advance the model across one edge, land #1 after it.
    task automatic tick();
        bit            exp_ar;
        bit            exp_rv;
        logic [DW+1:0] head;
        #2;
        exp_ar = !in_rst_m && (exp_q.size() < 2);
        exp_rv = (exp_q.size() > 0);
        if (started) begin
            chk("arready", bus.arready, exp_ar);
            chk("rvalid", bus.rvalid, exp_rv);
            chk("rd_count", rd_count, exp_count);
            if (exp_rv) begin
                head = exp_q[0];
                chk("rdata", bus.rdata, head[DW-1:0]);
                chk("rresp", bus.rresp, head[DW+1:DW]);
            end else if (in_rst_m) begin
                chk("rst_rdata", bus.rdata, 64'd0);
                chk("rst_rresp", bus.rresp, 64'd0);
            end
        end
        if (bus.arvalid && bus.arready) obs_accepts++;
        if (rst) begin
            exp_q.delete();
            exp_count = 32'd0;
            in_rst_m  = 1'b1;
        end else begin
            if (exp_rv && bus.rready) begin
                void'(exp_q.pop_front());
                exp_count = exp_count + 32'd1;
            end
            if (bus.arvalid && exp_ar) exp_q.push_back(beat(bus.araddr));
            in_rst_m = 1'b0;
        end
        if (wr_en) shadow[wr_addr] = wr_data;
        @(posedge clk);
        #1;
        started = 1'b1;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        bus.araddr = '0; bus.arprot = 3'd0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        repeat (3) tick();
        chk("reset_arready", bus.arready, 64'd0);
        chk("reset_rvalid", bus.rvalid, 64'd0);
        chk("reset_rdata", bus.rdata, 64'd0);
        chk("reset_count", rd_count, 64'd0);
        rst = 1'b0;
        tick();
        chk("arready_after_reset", bus.arready, 64'd1);

        // Fill the memory with random words.
        for (int i = 0; i < DEPTH; i++) begin
            wr_en = 1'b1; wr_addr = IW'(i); wr_data = DW'($urandom);
            tick();
        end
        wr_en = 1'b0;

        // Single read of word 5.
        wr_en = 1'b1; wr_addr = IW'(5); wr_data = 16'hBEEF;
        tick();
        wr_en = 1'b0;
        bus.araddr = 32'h0000_000A; bus.arvalid = 1'b1; bus.rready = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("single_rvalid", bus.rvalid, 64'd1);
        chk("single_rdata", bus.rdata, 64'hBEEF);
        chk("single_rresp", bus.rresp, 64'd0);
        tick();
        chk("single_count", rd_count, 64'd1);

        // Streaming 16 back-to-back reads.
        for (int i = 0; i < 16; i++) begin
            bus.araddr = 32'(i * 2); bus.arvalid = 1'b1;
            tick();
        end
        bus.arvalid = 1'b0;
        tick();
        chk("stream_count", rd_count, 64'd17);

        // Backpressure with arvalid held.
        bus.rready = 1'b0; obs_accepts = 0; bus.arvalid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.araddr = 32'(2 * (100 + obs_accepts));
            tick();
        end
        chk("bp_accepts", obs_accepts, 64'd2);
        chk("bp_arready_low", bus.arready, 64'd0);
        bus.arvalid = 1'b0; bus.rready = 1'b1;
        repeat (3) tick();
        chk("bp_arready_back", bus.arready, 64'd1);
        chk("bp_drained", bus.rvalid, 64'd0);

        // Read-first collision on word 3.
        wr_en = 1'b1; wr_addr = IW'(3); wr_data = 16'h1111;
        tick();
        wr_data = 16'h2222; bus.araddr = 32'h0000_0006; bus.arvalid = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("collision_old", bus.rdata, 64'h1111);
        tick();
        bus.arvalid = 1'b0;
        chk("collision_new", bus.rdata, 64'h2222);
        tick();

        // Out-of-range byte address 0x800.
        bus.araddr = 32'h0000_0800; bus.arvalid = 1'b1;
        tick();
        bus.arvalid = 1'b0;
`ifdef AXIL_READ_RESPONDER_RANGE_ERR_EN
        chk("oob_rresp", bus.rresp, 64'd2);
        chk("oob_rdata", bus.rdata, 64'd0);
`else
        chk("oob_rresp", bus.rresp, 64'd0);
        chk("oob_rdata", bus.rdata, shadow[0]);
`endif
        tick();

        // Reset with two beats pending.
        bus.rready = 1'b0; bus.arvalid = 1'b1; bus.araddr = 32'h0000_0010;
        tick();
        bus.araddr = 32'h0000_0012;
        tick();
        bus.arvalid = 1'b0;
        chk("mid_pending_rvalid", bus.rvalid, 64'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_rvalid", bus.rvalid, 64'd0);
        chk("mid_rst_count", rd_count, 64'd0);
        chk("mid_rst_arready", bus.arready, 64'd0);
        tick();
        rst = 1'b0; bus.rready = 1'b1;
        tick();
        chk("mid_after_arready", bus.arready, 64'd1);
        chk("mid_after_rvalid", bus.rvalid, 64'd0);
        tick();

        // Random traffic including loads, collisions, out-of-range and rare resets.
        for (int i = 0; i < 600; i++) begin
            bus.arvalid = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) bus.araddr = $urandom;
            else bus.araddr = 32'($urandom_range(0, 4 * DEPTH + 7));
            bus.arprot = 3'($urandom);
            bus.rready = ($urandom_range(0, 9) < 7);
            wr_en      = ($urandom_range(0, 1) == 1);
            wr_addr    = IW'($urandom);
            wr_data    = DW'($urandom);
            rst        = ($urandom_range(0, 99) == 0);
            tick();
        end
        rst = 1'b0; bus.arvalid = 1'b0; wr_en = 1'b0; bus.rready = 1'b1;
        repeat (4) tick();
        chk("final_empty", bus.rvalid, 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
